// File: rtl/add16_dr_sequencer.sv
// add16_dr_sequencer
// Feeds binary operand pairs to a 16-bit dual-rail adder core and collects
// its result. Operands are encoded to dual-rail, driven after a spacer phase,
// and the adder is strobed once. The dual-rail result is watched until it is
// complete or illegal, or until the timeout expires. It is then decoded to a
// wrapped 16-bit sum with an error flag and held until the consumer takes it.
// All outputs are registered.

module add16_dr_sequencer #(
    parameter int SPACER_MIN = 1,   // minimum spacer cycles before data is driven
    parameter int TIMEOUT    = 64   // cycles allowed in SPACER or WAIT, 2..255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic [31:0] r1_p,
    output logic [31:0] r2_p,
    output logic        add_strobe,
    input  logic [31:0] r_result_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SPACER = 3'd1;
    localparam logic [2:0] S_DRIVE  = 3'd2;
    localparam logic [2:0] S_STROBE = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_HOLD   = 3'd5;

    localparam logic [7:0] SPACER_MIN_C = 8'(SPACER_MIN);
    localparam logic [7:0] TIMEOUT_C    = 8'(TIMEOUT);
    // The counter holds cycles elapsed since the phase began, so leaving at
    // TIMEOUT-1 makes HOLD land exactly TIMEOUT cycles after the reference.
    localparam logic [7:0] TIMEOUT_M1   = 8'(TIMEOUT - 1);

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic [7:0]  cnt;
    logic [15:0] a_q;
    logic [15:0] b_q;

    logic        res_null;
    logic        res_illegal;
    logic        res_complete;
    logic [15:0] res_value;

    logic [15:0] hold_sum;
    logic        hold_err;
    logic        drive_ops;

    // Bit i becomes rail pair {~v[i], v[i]}: 01 is logic 1 and 10 is logic 0.
    function automatic logic [31:0] dr_encode(input logic [15:0] v);
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) begin
            p[2*i]   = v[i];
            p[2*i+1] = ~v[i];
        end
        return p;
    endfunction

    // Classify the incoming dual-rail result: null, illegal or complete.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        res_illegal  = 1'b0;
        res_complete = 1'b1;
        res_value    = '0;
        for (int i = 0; i < 16; i++) begin
            if (r_result_p[2*i+1] && r_result_p[2*i]) begin
                res_illegal = 1'b1;
            end
            if (r_result_p[2*i+1] == r_result_p[2*i]) begin
                res_complete = 1'b0;
            end
            res_value[i] = r_result_p[2*i];
        end
        res_null = (r_result_p == 32'h0);
    end

    // Next-state logic, plus the sum/error captured on entry to HOLD.
    always_comb begin
        next_state = state;
        hold_sum   = '0;
        hold_err   = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    next_state = S_SPACER;
                end
            end
            S_SPACER: begin
                if (cnt >= SPACER_MIN_C && res_null) begin
                    next_state = S_DRIVE;
                end else if (cnt >= TIMEOUT_M1) begin
                    next_state = S_HOLD;
                    hold_err   = 1'b1;
                end
            end
            S_DRIVE:  next_state = S_STROBE;
            S_STROBE: next_state = S_WAIT;
            S_WAIT: begin
                // An illegal pair wins over completeness.
                if (res_illegal) begin
                    next_state = S_HOLD;
                    hold_err   = 1'b1;
                end else if (res_complete) begin
                    next_state = S_HOLD;
                    hold_sum   = res_value;
                end else if (cnt >= TIMEOUT_M1) begin
                    next_state = S_HOLD;
                    hold_err   = 1'b1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Operands are on the buses from DRIVE through WAIT, and at spacer otherwise.
    assign drive_ops = (next_state == S_DRIVE) || (next_state == S_STROBE) ||
                       (next_state == S_WAIT);

    // State, counter, operand capture and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
            state      <= S_IDLE;
            cnt        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            in_ready   <= 1'b0;
            r1_p       <= '0;
            r2_p       <= '0;
            add_strobe <= 1'b0;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_err    <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state == S_IDLE);

            if (state == S_IDLE && next_state == S_SPACER) begin
                a_q <= in_a;
                b_q <= in_b;
            end

            // Restart at 1 when a timed phase begins, then saturate at TIMEOUT.
            if (state == S_IDLE || state == S_STROBE) begin
                cnt <= 8'd1;
            end else if (cnt != TIMEOUT_C) begin
                cnt <= cnt + 8'd1;
            end

            r1_p       <= drive_ops ? dr_encode(a_q) : 32'h0;
            r2_p       <= drive_ops ? dr_encode(b_q) : 32'h0;
            add_strobe <= (next_state == S_STROBE);
            out_valid  <= (next_state == S_HOLD);

            if (state != S_HOLD && next_state == S_HOLD) begin
                out_sum <= hold_sum;
                out_err <= hold_err;
            end
        end
    end

endmodule

// File: tb/tb_add16_dr_sequencer.sv
// tb_add16_dr_sequencer
// Directed stimulus with hand-computed expectations. A behavioural adder model
// answers the strobe, and a scoreboard monitor checks each accepted result.

module tb_add16_dr_sequencer;

    localparam int SPACER_MIN = 1;
    localparam int TIMEOUT    = 64;

    localparam int M_NORMAL  = 0;   // complete result after model_delay cycles
    localparam int M_ILLEGAL = 1;   // result with pair 3 forced to 11
    localparam int M_NULL    = 2;   // result never leaves spacer
    localparam int M_STALE   = 3;   // stuck non-null, incomplete result

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [31:0] r1_p;
    logic [31:0] r2_p;
    logic        add_strobe;
    logic [31:0] r_result_p;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_err;

    typedef struct packed {
        logic [15:0] sum;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   model_mode  = M_NORMAL;
    int   model_delay = 1;
    int   since = -1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    add16_dr_sequencer #(
        .SPACER_MIN(SPACER_MIN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .r1_p      (r1_p),
        .r2_p      (r2_p),
        .add_strobe(add_strobe),
        .r_result_p(r_result_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_err   (out_err)
    );

    function automatic logic [31:0] enc(input logic [15:0] v);
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) begin
            p[2*i]   = v[i];
            p[2*i+1] = ~v[i];
        end
        return p;
    endfunction

    function automatic logic [15:0] dec(input logic [31:0] p);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[i] = p[2*i];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Adder model: answers model_delay cycles after the strobe cycle and
    // returns to spacer as soon as the operand buses go back to spacer.
    always @(posedge clk) begin
        #1;
        if (add_strobe) since = 0;
        else if (since >= 0) since = since + 1;
        if (r1_p == 32'h0 && r2_p == 32'h0 && !add_strobe) since = -1;
        case (model_mode)
            M_NORMAL:  r_result_p = (since >= model_delay) ?
                                    enc(dec(r1_p) + dec(r2_p)) : 32'h0;
            M_ILLEGAL: r_result_p = (since >= model_delay) ?
                                    (enc(dec(r1_p) + dec(r2_p)) | 32'h0000_00C0) : 32'h0;
            M_STALE:   r_result_p = 32'h0000_0002;
            default:   r_result_p = 32'h0;
        endcase
    end

    // Scoreboard monitor: every accepted result must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got sum %0h err %0b, expected no result", out_sum, out_err);
            end else begin
                e = sb.pop_front();
                check("result_sum", 32'(out_sum), 32'(e.sum));
                check("result_err", 32'(out_err), 32'(e.err));
            end
        end
    end

    // Wait for in_ready (bounded), present one operand pair, return cycle 0 of the accept.
    task automatic send(input logic [15:0] a, input logic [15:0] b, output int t0);
        int k;
        k = 0;
        while (!in_ready && k < 200) begin
            tick();
            k++;
        end
        if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        t0       = cyc - 1;
        in_valid = 1'b0;
        in_a     = 16'hDEAD;
        in_b     = 16'hBEEF;
    endtask

    task automatic wait_valid(output int t);
        int k;
        k = 0;
        while (!out_valid && k < 300) begin
            tick();
            k++;
        end
        if (!out_valid) check("out_valid_wait", 32'(out_valid), 32'd1);
        t = cyc;
    endtask

    task automatic wait_strobe(output int t);
        int k;
        k = 0;
        while (!add_strobe && k < 100) begin
            tick();
            k++;
        end
        if (!add_strobe) check("add_strobe_wait", 32'(add_strobe), 32'd1);
        t = cyc;
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready",   32'(in_ready),   32'd0);
        check("rst_r1_p",       r1_p,            32'h0);
        check("rst_r2_p",       r2_p,            32'h0);
        check("rst_add_strobe", 32'(add_strobe), 32'd0);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_out_sum",    32'(out_sum),    32'd0);
        check("rst_out_err",    32'(out_err),    32'd0);
    endtask

    initial begin
        int  t0, t1, t, ts;
        logic strobe_seen;
        logic stable_ok;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        out_ready  = 1'b1;
        r_result_p = '0;

        // Reset state.
        tick();
        tick();
        check_reset_outputs();
        rst = 1'b0;
        tick();
        check("in_ready_after_reset", 32'(in_ready), 32'd1);

        // 2 + 4 with the result arriving two cycles after the strobe.
        model_mode  = M_NORMAL;
        model_delay = 2;
        send(16'd2, 16'd4, t0);
        sb.push_back('{sum: 16'd6, err: 1'b0});
        check("in_ready_busy", 32'(in_ready), 32'd0);
        while (r1_p == 32'h0 && cyc - t0 < 20) tick();
        check("r1_p_driven", r1_p, 32'hAAAA_AAA6);
        check("r2_p_driven", r2_p, 32'hAAAA_AA9A);
        wait_valid(t);
        check("latency_delay2", 32'(t - t0), 32'd6);
        check("bus_spacer_in_hold", r1_p, 32'h0);
        tick();
        check("out_valid_drops", 32'(out_valid), 32'd0);

        // 0x8888 + 0x8888: carry out of bit 15 is dropped; first-WAIT completion.
        model_delay = 1;
        send(16'h8888, 16'h8888, t0);
        sb.push_back('{sum: 16'h1110, err: 1'b0});
        wait_valid(t);
        check("latency_min", 32'(t - t0), 32'(SPACER_MIN + 4));

        // Back-to-back operations at full throughput.
        send(16'hFFFF, 16'h0001, t0);
        sb.push_back('{sum: 16'h0000, err: 1'b0});
        send(16'h1234, 16'h4321, t1);
        sb.push_back('{sum: 16'h5555, err: 1'b0});
        check("throughput", 32'(t1 - t0), 32'(SPACER_MIN + 5));
        wait_valid(t);
        tick();

        // Illegal pair 3 during WAIT.
        model_mode = M_ILLEGAL;
        send(16'd5, 16'd6, t0);
        sb.push_back('{sum: 16'h0000, err: 1'b1});
        wait_valid(t);
        repeat (4) tick();

        // Result never completes: WAIT timeout TIMEOUT cycles after the strobe.
        model_mode = M_NULL;
        send(16'd7, 16'd8, t0);
        sb.push_back('{sum: 16'h0000, err: 1'b1});
        wait_strobe(ts);
        wait_valid(t);
        check("wait_timeout_cycles", 32'(t - ts), 32'(TIMEOUT));
        tick();

        // Stale non-null result: SPACER timeout, strobe never pulses.
        model_mode  = M_STALE;
        strobe_seen = 1'b0;
        send(16'd9, 16'd9, t0);
        sb.push_back('{sum: 16'h0000, err: 1'b1});
        t = 0;
        while (!out_valid && cyc - t0 < 300) begin
            strobe_seen = strobe_seen | add_strobe;
            tick();
        end
        t = cyc;
        model_mode = M_NORMAL;
        check("spacer_timeout_valid", 32'(out_valid), 32'd1);
        check("spacer_no_strobe", 32'(strobe_seen), 32'd0);
        check("spacer_timeout_window", 32'((t - t0 >= TIMEOUT) && (t - t0 <= TIMEOUT + 1)), 32'd1);
        tick();
        tick();

        // Consumer stalls for 20 cycles; in_valid during HOLD is ignored.
        model_delay = 1;
        out_ready   = 1'b0;
        send(16'h1000, 16'h0234, t0);
        sb.push_back('{sum: 16'h1234, err: 1'b0});
        wait_valid(t);
        stable_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                in_valid = 1'b1;
                in_a     = 16'hFFFF;
                in_b     = 16'hFFFF;
            end
            if (i == 15) in_valid = 1'b0;
            if (!out_valid || out_sum != 16'h1234 || out_err || in_ready) stable_ok = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        check("hold_stable", 32'(stable_ok), 32'd1);
        out_ready = 1'b1;
        tick();
        check("hold_release_valid", 32'(out_valid), 32'd0);
        check("hold_release_ready", 32'(in_ready), 32'd1);
        repeat (10) tick();
        check("no_ghost_op", 32'(out_valid), 32'd0);

        // Reset in the middle of WAIT aborts the operation.
        model_mode = M_NULL;
        send(16'd1, 16'd1, t0);
        wait_strobe(ts);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_reset_outputs();
        rst = 1'b0;
        tick();
        check("in_ready_after_abort", 32'(in_ready), 32'd1);
        model_mode = M_NORMAL;
        send(16'd100, 16'd20000, t0);
        sb.push_back('{sum: 16'd20100, err: 1'b0});
        wait_valid(t);
        repeat (5) tick();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/add16_dr_sequencer.md
Name: add16_dr_sequencer

Overview:
- Upstream feeder and result collector for the 16-bit dual-rail adder core.
- Accepts binary operand pairs on a valid/ready handshake and encodes them to 32-bit dual-rail buses.
- Sequences the spacer/data phases and pulses the adder strobe.
- Detects completion on the dual-rail result bus, then decodes the result and returns a 16-bit wrapped sum with an error flag.

Parameters:
- SPACER_MIN, 1: minimum cycles operand buses are held at spacer (all zero) before data is driven.
- TIMEOUT, 64: maximum cycles spent in SPACER or WAIT before the operation aborts with an error; range 2..255.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  16  operand A, binary.
- in_b  in  16  operand B, binary.
- r1_p  out  32  operand A, dual-rail, to adder.
- r2_p  out  32  operand B, dual-rail, to adder.
- add_strobe  out  1  one-cycle clock/strobe pulse to adder.
- r_result_p  in  32  adder result, dual-rail.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  16  decoded sum, (in_a + in_b) mod 2^16.
- out_err  out  1  qualifies out_sum; 1 = illegal code or timeout.

Behaviour:
- Dual-rail code per bit i:
  - pair {p[2i+1], p[2i]}: 2'b01 = logic 1, 2'b10 = logic 0, 2'b00 = spacer (null), 2'b11 = illegal.
  - Bus complete when all 16 pairs are 01 or 10.
  - Bus null when it equals 32'h0.
- Reset:
  - state IDLE; in_ready=0 during the reset cycle, then 1.
  - r1_p, r2_p = 0; add_strobe=0; out_valid=0; out_sum=0; out_err=0; counters cleared.
  - Reset mid-operation aborts immediately: no out_valid, buses return to spacer next cycle.
- FSM:
  - IDLE: in_ready=1, buses at spacer. On in_valid&&in_ready, register in_a/in_b and go to SPACER. in_ready is 0 in every other state.
  - SPACER: buses held 0; cycle counter runs.
    - Exit to DRIVE once counter >= SPACER_MIN and r_result_p is null.
    - If counter reaches TIMEOUT first, go to HOLD with out_err=1 and out_sum=0.
  - DRIVE: r1_p/r2_p carry the encoded operands; one cycle; go to STROBE.
  - STROBE: add_strobe=1 for exactly this cycle; operands stay driven; go to WAIT; clear counter.
  - WAIT: operands stay driven; evaluate r_result_p every cycle.
    - Any 11 pair: go to HOLD, out_err=1, out_sum=0. Checked before completeness.
    - Else if complete: out_sum[i] = p[2i], out_err=0, go to HOLD.
    - Else if counter reaches TIMEOUT: go to HOLD, out_err=1, out_sum=0.
  - HOLD: out_valid=1; out_sum/out_err stable; operand buses return to spacer. On out_ready go to IDLE; out_valid drops the next cycle.
- Latency:
  - With the result complete on the first WAIT cycle and out_ready=1, accept at cycle 0 gives out_valid at cycle SPACER_MIN+4. This is 5 cycles with the default SPACER_MIN.
  - Throughput: one operation per SPACER_MIN+5 cycles minimum.
- Arithmetic: no carry-out port; the carry beyond bit 15 is discarded, so 16-bit wrap-around is the defined result.
- Simultaneous events:
  - out_ready high on the first HOLD cycle is honoured. HOLD lasts exactly one cycle.
  - in_valid in any non-IDLE state is ignored; in_a/in_b are not sampled.
- Counters saturate at TIMEOUT; no wrap.

Test Plan:
- in_a=2, in_b=4; model adder returns 0x...01 pattern for 6 two cycles after strobe -> out_valid with out_sum=6, out_err=0; r1_p=32'hAAAAAAA6 while driven.
- in_a=34952, in_b=34952 (0x8888) -> out_sum=4368 (0x1110), carry dropped, out_err=0.
- Model drives pair 3 of r_result_p to 2'b11 during WAIT -> out_err=1, out_sum=0, single out_valid.
- Model never completes the result (stays null) with TIMEOUT=64 -> out_valid exactly 64 cycles after the STROBE cycle, out_err=1; stale non-null result held through SPACER -> SPACER timeout error, add_strobe never pulses.
- out_ready held low 20 cycles -> out_valid and out_sum stable throughout, in_ready=0, new in_valid ignored; releasing out_ready returns to IDLE next cycle.
- rst asserted during WAIT -> next cycle all outputs at reset values, buses 0; a following op 100+20000 returns 20100.
